ap_handshake_perf_monitor: RTL and testbench
============================================

# ap_handshake_perf_monitor

Synthesizable, parametrised per-channel performance monitor for HLS block-level handshakes (ap_start/ap_done/ap_continue). It tracks up to NUM_CH kernel or loop instances and accumulates transaction count, busy cycles, output-stall cycles and latency statistics. It replaces simulation-only CSV status dumping with on-chip counters that a testbench or a host register bridge reads through a one-cycle-latency read port.

## Interface
- NUM_CH, 5, number of monitored channels (1..32)
- CNT_W, 32, width of every counter and of rd_data (8..64)
- clock  in  1  single clock domain
- reset  in  1  synchronous, active-high; clears all state and counters
- ap_start  in  NUM_CH  per-channel start
- ap_done  in  NUM_CH  per-channel done
- ap_continue  in  NUM_CH  per-channel continue; tie high for channels without it
- finish  in  1  freeze: while high, no counter or state updates
- clr  in  1  synchronous counter clear; channel states are kept
- rd_en  in  1  read request
- rd_ch  in  $clog2(NUM_CH) (min 1)  channel index
- rd_sel  in  3  counter select
- rd_valid  out  1  read data valid, one cycle after rd_en
- rd_data  out  CNT_W  selected counter value
- rd_err  out  1  with rd_valid: rd_ch >= NUM_CH or rd_sel unmapped
- ch_busy  out  NUM_CH  channel state != IDLE

## Operation
- Per-channel FSM: IDLE, BUSY, DONE_WAIT.
- IDLE -> BUSY on ap_start=1. This is the accept cycle; the latency counter loads 1.
- BUSY: the latency counter increments each cycle. On ap_done=1:
  - latency is captured into last_lat on that cycle.
  - ap_continue=1 completes the transaction: trans_cnt+1, then go to IDLE, or stay in BUSY with the latency counter at 1 if ap_start=1 in the same cycle (back-to-back).
  - ap_continue=0 goes to DONE_WAIT.
- Start and done in the accept cycle (single-cycle kernel): latency=1. The transaction completes in the same cycle if ap_continue=1.
- DONE_WAIT: stall_cycles+1 on every cycle with ap_continue=0, including the first done cycle in BUSY. ap_continue=1 completes the transaction with the same start rules as BUSY.
- busy_cycles increments on every cycle the latency counter runs (accept cycle through first done cycle), so busy_cycles equals the sum of latencies.
- All counters saturate at 2^CNT_W-1 and never wrap.
- rd_sel map:
  - 0 trans_cnt
  - 1 busy_cycles
  - 2 stall_cycles
  - 3 last_lat
  - 4 max_lat
  - 5 min_lat
  - 6 ch_state, zero-extended: IDLE=0, BUSY=1, DONE_WAIT=2
  - 7 unmapped: rd_data=0, rd_err=1
- Priority: reset > finish > clr > normal update.
- clr sets counters to 0 and min_lat to all-ones. A transaction in flight continues and is counted from the clr cycle onward.
- finish freezes FSMs and counters. Reads remain serviced.

## Timing
- Reset values:
  - rd_valid=0, rd_data=0, rd_err=0, ch_busy=0
  - all FSMs in IDLE
  - counters 0, min_lat all-ones
- Read latency is exactly 1 cycle. Reads are pipelined: one read per cycle with no back-pressure.
- rd_data reflects counter values as of the end of the rd_en cycle, i.e. before that cycle's update.
- ch_busy is registered and goes high the cycle after the accept cycle.
- Reset mid-transaction abandons the transaction; nothing is counted.

## Configuration
- PERF_MON_MINMAX_EN defined: max_lat/min_lat registers per channel, updated at latency capture.
- Not defined: no min/max registers are synthesised; rd_sel 4/5 return rd_data=0 and rd_err=1.

## Structure
- Package perf_mon_pkg holds:
  - the ch_state_e enum
  - rd_sel localparams (SEL_TRANS..SEL_STATE)
  - the saturating-increment function
- Sub-module ap_hs_ch_tracker: one channel's FSM, latency counter and counters, instantiated NUM_CH times by generate.
- The top level holds the read mux and output registers.

## Test plan
- Single transaction: start at cycle 10, done with continue=1 at cycle 14 -> trans_cnt=1, last_lat=5, busy_cycles=5, stall_cycles=0.
- Back-to-back: done+continue+start in the same cycle, second done 3 cycles later -> trans_cnt=2, second last_lat=4, no IDLE cycle.
- Stall: done at latency 3 with continue low for 4 cycles -> stall_cycles=4, last_lat=3, trans_cnt increments only when continue rises.
- Single-cycle kernel with start=done=continue=1 for 3 consecutive cycles -> trans_cnt=3, last_lat=1, min_lat=1 (macro on), max_lat=1.
- Saturation with CNT_W=8 and a 300-cycle transaction -> busy_cycles=255, last_lat=255.
- Reads and control:
  - rd_ch=NUM_CH -> rd_err=1, rd_data=0.
  - finish high mid-transaction -> counters frozen.
  - reset mid-transaction -> all counters 0, ch_busy=0 next cycle.

Source files
------------

// File: rtl/perf_mon_pkg.sv
// rtl/perf_mon_pkg.sv - shared types, read selects and saturating increment for the handshake perf monitor
package perf_mon_pkg;

  // Channel state, encoded as read back through the state select
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BUSY      = 2'd1,
    ST_DONE_WAIT = 2'd2
  } ch_state_e;

  // Read port counter selects; 7 is unmapped
  localparam logic [2:0] SEL_TRANS = 3'd0;
  localparam logic [2:0] SEL_BUSY  = 3'd1;
  localparam logic [2:0] SEL_STALL = 3'd2;
  localparam logic [2:0] SEL_LAST  = 3'd3;
  localparam logic [2:0] SEL_MAX   = 3'd4;
  localparam logic [2:0] SEL_MIN   = 3'd5;
  localparam logic [2:0] SEL_STATE = 3'd6;

  // Increment v, holding at the all-ones value of a w-bit counter
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] lim;
    lim = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    return (v >= lim) ? v : (v + 64'd1);
  endfunction

endpackage

// File: rtl/ap_hs_ch_tracker.sv
// rtl/ap_hs_ch_tracker.sv - one channel's ap_start/ap_done/ap_continue FSM, latency counter and statistics (min/max under PERF_MON_MINMAX_EN)
module ap_hs_ch_tracker
  import perf_mon_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_finish,
  input  logic             i_clr,
  input  logic             i_start,
  input  logic             i_done,
  input  logic             i_cont,
  output logic [CNT_W-1:0] o_trans,
  output logic [CNT_W-1:0] o_busy_cyc,
  output logic [CNT_W-1:0] o_stall,
  output logic [CNT_W-1:0] o_last_lat,
`ifdef PERF_MON_MINMAX_EN
  output logic [CNT_W-1:0] o_max_lat,
  output logic [CNT_W-1:0] o_min_lat,
`endif
  output ch_state_e        o_state,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ALL1 = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    logic [63:0] t;
    t = sat_inc(64'(v), CNT_W);
    return t[CNT_W-1:0];
  endfunction

  ch_state_e        r_state;
  logic [CNT_W-1:0] r_lat;
  logic [CNT_W-1:0] r_trans;
  logic [CNT_W-1:0] r_busy_cyc;
  logic [CNT_W-1:0] r_stall;
  logic [CNT_W-1:0] r_last_lat;
`ifdef PERF_MON_MINMAX_EN
  logic [CNT_W-1:0] r_max_lat;
  logic [CNT_W-1:0] r_min_lat;
`endif

  logic             w_in_idle;
  logic             w_in_busy;
  logic             w_in_dw;
  logic             w_accept;
  logic             w_run;
  logic             w_capture;
  logic             w_complete;
  logic             w_stall;
  logic             w_b2b;
  logic             w_dw_start;
  logic [CNT_W-1:0] w_lat_now;
  logic [CNT_W-1:0] w_busy_1;
  logic [CNT_W-1:0] w_busy_2;

  assign w_in_idle  = (r_state == ST_IDLE);
  assign w_in_busy  = (r_state == ST_BUSY);
  assign w_in_dw    = (r_state == ST_DONE_WAIT);
  // Latency of the current cycle: 1 in the accept cycle, else one more than last cycle
  assign w_lat_now  = w_in_idle ? ONE : inc(r_lat);
  assign w_accept   = w_in_idle & i_start;
  assign w_run      = w_accept | w_in_busy;
  assign w_capture  = w_run & i_done;
  assign w_complete = (w_capture | w_in_dw) & i_cont;
  assign w_stall    = (w_capture | w_in_dw) & ~i_cont;
  // A done+continue+start cycle is both the last cycle of one transaction and
  // latency 1 of the next, so it contributes to busy_cycles twice
  assign w_b2b      = w_in_busy & i_done & i_cont & i_start;
  assign w_dw_start = w_in_dw & i_cont & i_start;
  assign w_busy_1   = inc(r_busy_cyc);
  assign w_busy_2   = inc(w_busy_1);

  // Channel FSM, latency counter and statistics; reset > finish > clr > update
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_lat      <= '0;
      r_trans    <= '0;
      r_busy_cyc <= '0;
      r_stall    <= '0;
      r_last_lat <= '0;
`ifdef PERF_MON_MINMAX_EN
      r_max_lat  <= '0;
      r_min_lat  <= ALL1;
`endif
    end else if (!i_finish) begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_lat <= ONE;
            if (i_done && i_cont) r_state <= ST_IDLE;
            else if (i_done)      r_state <= ST_DONE_WAIT;
            else                  r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (i_done) begin
            if (!i_cont) begin
              r_state <= ST_DONE_WAIT;
            end else if (i_start) begin
              r_state <= ST_BUSY;
              r_lat   <= ONE;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_lat <= w_lat_now;
          end
        end
        ST_DONE_WAIT: begin
          if (i_cont) begin
            if (i_start) begin
              r_state <= ST_BUSY;
              r_lat   <= ONE;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (i_clr) begin
        r_trans    <= '0;
        r_busy_cyc <= '0;
        r_stall    <= '0;
        r_last_lat <= '0;
`ifdef PERF_MON_MINMAX_EN
        r_max_lat  <= '0;
        r_min_lat  <= ALL1;
`endif
      end else begin
        if (w_run || w_dw_start) r_busy_cyc <= w_b2b ? w_busy_2 : w_busy_1;
        if (w_complete)          r_trans    <= inc(r_trans);
        if (w_stall)             r_stall    <= inc(r_stall);
        if (w_capture) begin
          r_last_lat <= w_lat_now;
`ifdef PERF_MON_MINMAX_EN
          if (w_lat_now > r_max_lat) r_max_lat <= w_lat_now;
          if (w_lat_now < r_min_lat) r_min_lat <= w_lat_now;
`endif
        end
      end
    end
  end

  assign o_trans    = r_trans;
  assign o_busy_cyc = r_busy_cyc;
  assign o_stall    = r_stall;
  assign o_last_lat = r_last_lat;
`ifdef PERF_MON_MINMAX_EN
  assign o_max_lat  = r_max_lat;
  assign o_min_lat  = r_min_lat;
`endif
  assign o_state    = r_state;
  assign o_busy     = ~w_in_idle;

endmodule

// File: rtl/ap_handshake_perf_monitor.sv
// rtl/ap_handshake_perf_monitor.sv - per-channel HLS handshake perf monitor with 1-cycle read port (min/max under PERF_MON_MINMAX_EN)
module ap_handshake_perf_monitor
  import perf_mon_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int CNT_W  = 32,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [NUM_CH-1:0] i_ap_start,
  input  logic [NUM_CH-1:0] i_ap_done,
  input  logic [NUM_CH-1:0] i_ap_continue,
  input  logic              i_finish,
  input  logic              i_clr,
  input  logic              i_rd_en,
  input  logic [CH_W-1:0]   i_rd_ch,
  input  logic [2:0]        i_rd_sel,
  output logic              o_rd_valid,
  output logic [CNT_W-1:0]  o_rd_data,
  output logic              o_rd_err,
  output logic [NUM_CH-1:0] o_ch_busy
);

  // Per-channel arrays are padded to a power of two so any rd_ch indexes safely
  localparam int              CH_PAD   = 1 << CH_W;
  localparam logic [CH_W:0]   NUM_CH_L = NUM_CH[CH_W:0];

  logic [CNT_W-1:0]  w_trans    [CH_PAD];
  logic [CNT_W-1:0]  w_busy_cyc [CH_PAD];
  logic [CNT_W-1:0]  w_stall    [CH_PAD];
  logic [CNT_W-1:0]  w_last_lat [CH_PAD];
`ifdef PERF_MON_MINMAX_EN
  logic [CNT_W-1:0]  w_max_lat  [CH_PAD];
  logic [CNT_W-1:0]  w_min_lat  [CH_PAD];
`endif
  logic [1:0]        w_state    [CH_PAD];
  logic [NUM_CH-1:0] w_ch_busy;

  logic [CNT_W-1:0]  w_mux_data;
  logic              w_mux_err;

  logic              r_rd_valid;
  logic [CNT_W-1:0]  r_rd_data;
  logic              r_rd_err;

  for (genvar g = 0; g < CH_PAD; g++) begin : g_ch
    if (g < NUM_CH) begin : g_trk
      ch_state_e w_st;
      ap_hs_ch_tracker #(.CNT_W(CNT_W)) u_trk (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_finish   (i_finish),
        .i_clr      (i_clr),
        .i_start    (i_ap_start[g]),
        .i_done     (i_ap_done[g]),
        .i_cont     (i_ap_continue[g]),
        .o_trans    (w_trans[g]),
        .o_busy_cyc (w_busy_cyc[g]),
        .o_stall    (w_stall[g]),
        .o_last_lat (w_last_lat[g]),
`ifdef PERF_MON_MINMAX_EN
        .o_max_lat  (w_max_lat[g]),
        .o_min_lat  (w_min_lat[g]),
`endif
        .o_state    (w_st),
        .o_busy     (w_ch_busy[g])
      );
      assign w_state[g] = w_st;
    end else begin : g_pad
      assign w_trans[g]    = '0;
      assign w_busy_cyc[g] = '0;
      assign w_stall[g]    = '0;
      assign w_last_lat[g] = '0;
`ifdef PERF_MON_MINMAX_EN
      assign w_max_lat[g]  = '0;
      assign w_min_lat[g]  = '0;
`endif
      assign w_state[g]    = 2'd0;
    end
  end

  // Read mux: selects a counter of the addressed channel, flags bad channel/select
  always_comb begin
    w_mux_data = '0;
    w_mux_err  = 1'b0;
    if ({1'b0, i_rd_ch} >= NUM_CH_L) begin
      w_mux_err = 1'b1;
    end else begin
      case (i_rd_sel)
        SEL_TRANS: w_mux_data = w_trans[i_rd_ch];
        SEL_BUSY:  w_mux_data = w_busy_cyc[i_rd_ch];
        SEL_STALL: w_mux_data = w_stall[i_rd_ch];
        SEL_LAST:  w_mux_data = w_last_lat[i_rd_ch];
`ifdef PERF_MON_MINMAX_EN
        SEL_MAX:   w_mux_data = w_max_lat[i_rd_ch];
        SEL_MIN:   w_mux_data = w_min_lat[i_rd_ch];
`endif
        SEL_STATE: w_mux_data = CNT_W'(w_state[i_rd_ch]);
        default:   w_mux_err  = 1'b1;
      endcase
    end
  end

  // Read output registers; reads keep working while finish is high
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= i_rd_en;
      r_rd_data  <= i_rd_en ? w_mux_data : '0;
      r_rd_err   <= i_rd_en & w_mux_err;
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_rd_err   = r_rd_err;
  assign o_ch_busy  = w_ch_busy;

endmodule

// File: tb/tb_ap_handshake_perf_monitor.sv
// tb/tb_ap_handshake_perf_monitor.sv - self-checking bench for ap_handshake_perf_monitor
module tb_ap_handshake_perf_monitor;
  import perf_mon_pkg::*;

  logic        clk;
  logic        i_reset;
  logic [4:0]  i_ap_start, i_ap_done, i_ap_continue;
  logic        i_finish, i_clr, i_rd_en;
  logic [2:0]  i_rd_ch, i_rd_sel;
  logic        o_rd_valid, o_rd_err;
  logic [31:0] o_rd_data;
  logic [4:0]  o_ch_busy;

  logic        b_start, b_done, b_cont, b_rd_en, b_rd_valid, b_rd_err, b_ch_busy;
  logic [0:0]  b_rd_ch;
  logic [2:0]  b_rd_sel;
  logic [7:0]  b_rd_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { logic [31:0] data; logic err; int cyc; } exp_t;
  typedef struct { logic [2:0] ch; logic [2:0] sel; logic [31:0] data; logic err; } vec_t;
  exp_t sb[$];
  vec_t vecs[$];

  ap_handshake_perf_monitor #(.NUM_CH(5), .CNT_W(32)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_ap_start(i_ap_start), .i_ap_done(i_ap_done),
    .i_ap_continue(i_ap_continue), .i_finish(i_finish), .i_clr(i_clr), .i_rd_en(i_rd_en),
    .i_rd_ch(i_rd_ch), .i_rd_sel(i_rd_sel), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .o_rd_err(o_rd_err), .o_ch_busy(o_ch_busy)
  );

  ap_handshake_perf_monitor #(.NUM_CH(1), .CNT_W(8)) dut_sat (
    .i_clock(clk), .i_reset(i_reset), .i_ap_start(b_start), .i_ap_done(b_done),
    .i_ap_continue(b_cont), .i_finish(1'b0), .i_clr(1'b0), .i_rd_en(b_rd_en),
    .i_rd_ch(b_rd_ch), .i_rd_sel(b_rd_sel), .o_rd_valid(b_rd_valid), .o_rd_data(b_rd_data),
    .o_rd_err(b_rd_err), .o_ch_busy(b_ch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle; the scoreboard is checked at the falling edge
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (sb.size() > 0 && sb[0].cyc + 1 <= cyc) begin
      e = sb.pop_front();
      chk("rd_valid", o_rd_valid, 1);
      chk("rd_data", o_rd_data, e.data);
      chk("rd_err", o_rd_err, e.err);
    end else begin
      chk("rd_valid_idle", o_rd_valid, 0);
    end
    @(posedge clk);
    #1;
    i_rd_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] ch, input logic [2:0] sel, input logic [31:0] d, input logic e);
    i_rd_en  = 1'b1;
    i_rd_ch  = ch;
    i_rd_sel = sel;
    sb.push_back('{data: d, err: e, cyc: cyc});
  endtask

  task automatic rd_mm(input logic [2:0] ch, input logic [2:0] sel, input logic [31:0] v);
`ifdef PERF_MON_MINMAX_EN
    rd(ch, sel, v, 1'b0);
`else
    rd(ch, sel, 32'd0, 1'b1);
`endif
  endtask

  task automatic add(input logic [2:0] ch, input logic [2:0] sel, input logic [31:0] d, input logic e);
    vecs.push_back('{ch: ch, sel: sel, data: d, err: e});
  endtask

  task automatic add_mm(input logic [2:0] ch, input logic [2:0] sel, input logic [31:0] v);
`ifdef PERF_MON_MINMAX_EN
    add(ch, sel, v, 1'b0);
`else
    add(ch, sel, 32'd0, 1'b1);
`endif
  endtask

  task automatic add_ch(input logic [2:0] ch, input int tr, input int bz, input int st,
                        input int last, input int mx, input int mn);
    add(ch, SEL_TRANS, 32'(tr), 1'b0);
    add(ch, SEL_BUSY, 32'(bz), 1'b0);
    add(ch, SEL_STALL, 32'(st), 1'b0);
    add(ch, SEL_LAST, 32'(last), 1'b0);
    add_mm(ch, SEL_MAX, 32'(mx));
    add_mm(ch, SEL_MIN, 32'(mn));
    add(ch, SEL_STATE, 32'd0, 1'b0);
  endtask

  task automatic brd(input logic ch, input logic [2:0] sel, input logic [7:0] d, input logic e);
    b_rd_en  = 1'b1;
    b_rd_ch  = ch;
    b_rd_sel = sel;
    tick();
    b_rd_en = 1'b0;
    chk("sat_rd_valid", b_rd_valid, 1);
    chk("sat_rd_data", b_rd_data, d);
    chk("sat_rd_err", b_rd_err, e);
  endtask

  initial begin
    // Expected final statistics per channel after the directed sequences
    add_ch(3'd0, 1, 5, 0, 5, 5, 5);
    add_ch(3'd1, 2, 7, 0, 4, 4, 3);
    add_ch(3'd2, 1, 3, 4, 3, 3, 3);
    add_ch(3'd3, 3, 3, 0, 1, 1, 1);
    add_ch(3'd4, 1, 5, 0, 5, 5, 5);
    add(3'd5, SEL_TRANS, 32'd0, 1'b1);
    add(3'd6, SEL_BUSY, 32'd0, 1'b1);
    add(3'd7, SEL_LAST, 32'd0, 1'b1);
    add(3'd0, 3'd7, 32'd0, 1'b1);
    add(3'd2, 3'd7, 32'd0, 1'b1);

    i_reset = 1'b1; i_ap_start = '0; i_ap_done = '0; i_ap_continue = '1;
    i_finish = 1'b0; i_clr = 1'b0; i_rd_en = 1'b0; i_rd_ch = '0; i_rd_sel = '0;
    b_start = 1'b0; b_done = 1'b0; b_cont = 1'b1; b_rd_en = 1'b0; b_rd_ch = '0; b_rd_sel = '0;
    repeat (3) tick();
    chk("rst_ch_busy", o_ch_busy, 0);
    chk("rst_rd_data", o_rd_data, 0);
    chk("rst_rd_err", o_rd_err, 0);
    i_reset = 1'b0;
    tick();
    rd(3'd0, SEL_TRANS, 32'd0, 1'b0); tick();
    rd(3'd4, SEL_STATE, 32'd0, 1'b0); tick();
    rd_mm(3'd1, SEL_MIN, 32'hFFFF_FFFF); tick();

    // Single transaction on ch0: latency 5
    i_ap_start[0] = 1'b1;
    chk("busy_before_accept", o_ch_busy[0], 0);
    tick();
    i_ap_start[0] = 1'b0;
    chk("busy_after_accept", o_ch_busy[0], 1);
    repeat (3) tick();
    i_ap_done[0] = 1'b1; tick(); i_ap_done[0] = 1'b0;
    chk("busy_after_done", o_ch_busy[0], 0);

    // Back-to-back on ch1: latencies 3 then 4
    i_ap_start[1] = 1'b1; tick(); i_ap_start[1] = 1'b0;
    tick();
    i_ap_done[1] = 1'b1; i_ap_start[1] = 1'b1; tick();
    i_ap_done[1] = 1'b0; i_ap_start[1] = 1'b0;
    chk("b2b_no_idle", o_ch_busy[1], 1);
    repeat (2) tick();
    i_ap_done[1] = 1'b1; tick(); i_ap_done[1] = 1'b0;

    // Stall on ch2: done at latency 3, continue low for 4 cycles
    i_ap_start[2] = 1'b1; tick(); i_ap_start[2] = 1'b0;
    tick();
    i_ap_done[2] = 1'b1; i_ap_continue[2] = 1'b0; tick(); i_ap_done[2] = 1'b0;
    rd(3'd2, SEL_TRANS, 32'd0, 1'b0); tick();
    rd(3'd2, SEL_STALL, 32'd2, 1'b0); tick();
    rd(3'd2, SEL_STATE, 32'd2, 1'b0); tick();
    i_ap_continue[2] = 1'b1; tick();

    // Single-cycle kernel on ch3, three in a row
    i_ap_start[3] = 1'b1; i_ap_done[3] = 1'b1;
    repeat (3) tick();
    i_ap_start[3] = 1'b0; i_ap_done[3] = 1'b0;

    // Finish freeze mid-transaction on ch4
    i_ap_start[4] = 1'b1; tick(); i_ap_start[4] = 1'b0;
    repeat (2) tick();
    i_finish = 1'b1;
    tick();
    rd(3'd4, SEL_BUSY, 32'd3, 1'b0); tick();
    rd(3'd4, SEL_STATE, 32'd1, 1'b0); i_ap_done[4] = 1'b1; tick();
    i_ap_done[4] = 1'b0;
    rd(3'd4, SEL_TRANS, 32'd0, 1'b0); tick();
    i_finish = 1'b0;
    tick();
    i_ap_done[4] = 1'b1; tick(); i_ap_done[4] = 1'b0;

    // Pipelined read burst of the vector table
    foreach (vecs[i]) begin
      rd(vecs[i].ch, vecs[i].sel, vecs[i].data, vecs[i].err);
      tick();
    end
    repeat (2) tick();

    // Counter clear keeps working afterwards
    i_clr = 1'b1; tick(); i_clr = 1'b0;
    rd(3'd0, SEL_TRANS, 32'd0, 1'b0); tick();
    rd(3'd1, SEL_BUSY, 32'd0, 1'b0); tick();
    rd_mm(3'd0, SEL_MIN, 32'hFFFF_FFFF); tick();
    rd(3'd3, SEL_LAST, 32'd0, 1'b0); tick();

    // Reset mid-transaction abandons it
    i_ap_start[0] = 1'b1; tick(); i_ap_start[0] = 1'b0;
    tick();
    chk("busy_pre_reset", o_ch_busy[0], 1);
    i_reset = 1'b1; tick(); i_reset = 1'b0;
    chk("busy_post_reset", o_ch_busy, 0);
    rd(3'd0, SEL_STATE, 32'd0, 1'b0); tick();
    rd(3'd0, SEL_BUSY, 32'd0, 1'b0); tick();
    rd(3'd3, SEL_TRANS, 32'd0, 1'b0); tick();
    repeat (2) tick();
    chk("sb_drained", sb.size(), 0);

    // Saturation on the 8-bit instance: 300-cycle transaction
    b_start = 1'b1; tick(); b_start = 1'b0;
    repeat (298) tick();
    b_done = 1'b1; tick(); b_done = 1'b0;
    brd(1'b0, SEL_BUSY, 8'd255, 1'b0);
    brd(1'b0, SEL_LAST, 8'd255, 1'b0);
    brd(1'b0, SEL_TRANS, 8'd1, 1'b0);
    brd(1'b0, SEL_STATE, 8'd0, 1'b0);
`ifdef PERF_MON_MINMAX_EN
    brd(1'b0, SEL_MAX, 8'd255, 1'b0);
`else
    brd(1'b0, SEL_MAX, 8'd0, 1'b1);
`endif
    brd(1'b1, SEL_TRANS, 8'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
